// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path
package uart_pkg;
  localparam int UART_TX_FIFO_DEPTH_DEFAULT = 16;
  localparam int UART_DATA_W = 8;
  typedef enum logic [2:0] {
    P_IDLE,
    P_START,
    P_WAIT_BUSY,
    P_WAIT_DONE,
    P_GAP
  } uart_pump_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with occupancy count, sticky overflow and flush
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TX_FIFO_DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Push,
  input  logic [UART_DATA_W-1:0] PushData,
  input  logic                   Pop,
  output logic [UART_DATA_W-1:0] PopData,
  input  logic                   Flush,
  output logic                   Full,
  output logic                   Empty,
  output logic [ADDR_W:0]        Count,
  output logic                   Overflow
);
  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr, rdPtr;
  logic doPush, doPop;
  always_comb begin
    doPush = Push && !Full && !Flush;
    doPop = Pop && !Empty && !Flush;
  end
  assign Full = Count == (ADDR_W+1)'(DEPTH);
  assign Empty = Count == '0;
  assign PopData = mem[rdPtr];
  always_ff @(posedge Clock)
    if (doPush) mem[wrPtr] <= PushData;
  // Flush shares the reset path: both clear pointers, occupancy and overflow
  always_ff @(posedge Clock) begin
    if (!Reset || Flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      Count <= '0;
      Overflow <= 1'b0;
    end else begin
      wrPtr <= wrPtr + ADDR_W'(doPush);
      rdPtr <= rdPtr + ADDR_W'(doPop);
      Count <= Count + (ADDR_W+1)'(doPush) - (ADDR_W+1)'(doPop);
      Overflow <= Overflow || (Push && Full);
    end
  end
endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: transmit FIFO plus pump that launches one byte per UART frame
// Define UART_TX_FIFO_IRQ_EN to enable the registered low-water interrupt TxIrq.
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TX_FIFO_DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   WrEn,
  input  logic [UART_DATA_W-1:0] WrData,
  input  logic                   Flush,
  output logic                   Full,
  output logic                   Empty,
  output logic [ADDR_W:0]        Count,
  output logic                   Overflow,
  output logic                   TxStart,
  output logic [UART_DATA_W-1:0] TxData,
  input  logic                   TxBusy,
  input  logic [ADDR_W:0]        TxIrqLevel,
  output logic                   TxIrq
);
  uart_pump_state_t state, stateNext;
  logic pop;
  logic [UART_DATA_W-1:0] popData;
  sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) fifo (
    .Clock(Clock),
    .Reset(Reset),
    .Push(WrEn),
    .PushData(WrData),
    .Pop(pop),
    .PopData(popData),
    .Flush(Flush),
    .Full(Full),
    .Empty(Empty),
    .Count(Count),
    .Overflow(Overflow)
  );
  always_comb begin
    stateNext = state;
    pop = 1'b0;
    case (state)
      P_IDLE: begin
        pop = !Empty && !Flush;
        stateNext = pop ? P_START : P_IDLE;
      end
      P_START:     stateNext = P_WAIT_BUSY;
      P_WAIT_BUSY: stateNext = TxBusy ? P_WAIT_DONE : P_WAIT_BUSY;
      P_WAIT_DONE: stateNext = TxBusy ? P_WAIT_DONE : P_GAP;
      P_GAP:       stateNext = P_IDLE;
      default:     stateNext = P_IDLE;
    endcase
  end
  // TxStart is registered from the next state so it is high exactly while in P_START
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= P_IDLE;
      TxStart <= 1'b0;
      TxData <= '0;
    end else begin
      state <= stateNext;
      TxStart <= stateNext == P_START;
      if (pop) TxData <= popData;
    end
  end
`ifdef UART_TX_FIFO_IRQ_EN
  always_ff @(posedge Clock)
    TxIrq <= Reset ? Count <= TxIrqLevel : 1'b0;
`else
  logic unusedIrqLevel;
  assign unusedIrqLevel = ^TxIrqLevel;
  assign TxIrq = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// tb_uart_tx_fifo_ctrl: directed and randomized bench checked against a queue-based model
module tb_uart_tx_fifo_ctrl;
  import uart_pkg::*;
  localparam int DEPTH = 16;
  localparam int AW = 4;
`ifdef UART_TX_FIFO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  logic Clock = 0, Reset = 0, WrEn = 0, Flush = 0, TxBusy = 0;
  logic [7:0] WrData = 0;
  logic [AW:0] TxIrqLevel = 0;
  logic Full, Empty, Overflow, TxStart, TxIrq;
  logic [AW:0] Count;
  logic [7:0] TxData;
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] mq[$];
  logic [7:0] sent[$];
  logic [7:0] mData = 0;
  bit mOvf = 0, mIrq = 0, startPrev = 0, stuck = 0;
  int busyLeft = 0, frameLen = 3, lastBusy = -100;
  always #5 Clock = ~Clock;
  uart_tx_fifo_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .WrEn(WrEn),
    .WrData(WrData),
    .Flush(Flush),
    .Full(Full),
    .Empty(Empty),
    .Count(Count),
    .Overflow(Overflow),
    .TxStart(TxStart),
    .TxData(TxData),
    .TxBusy(TxBusy),
    .TxIrqLevel(TxIrqLevel),
    .TxIrq(TxIrq)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask
  // One clock: model absorbs the inputs of the cycle, outputs are compared, transmitter reacts
  task automatic step();
    bit w, f, r;
    logic [7:0] d;
    logic [AW:0] lvl;
    int n0;
    w = WrEn;
    f = Flush;
    r = !Reset;
    d = WrData;
    lvl = TxIrqLevel;
    n0 = mq.size();
    @(posedge Clock);
    #1;
    cyc++;
    if (r) begin
      mq.delete();
      mOvf = 0;
      mIrq = 0;
      mData = 0;
      startPrev = 0;
      busyLeft = 0;
      TxBusy = 0;
      lastBusy = -100;
      chk("rst_txstart", TxStart, 0);
    end else begin
      mIrq = n0 <= int'(lvl);
      if (f) begin
        mq.delete();
        mOvf = 0;
        chk("flush_nopop", TxStart, 0);
      end else begin
        if (TxStart) begin
          chk("pop_nonempty", n0 > 0, 1);
          if (n0 > 0) mData = mq.pop_front();
          sent.push_back(TxData);
          chk("start_gap", cyc - lastBusy >= 3, 1);
          chk("start_single", startPrev, 0);
        end
        if (w) begin
          if (n0 == DEPTH) mOvf = 1;
          else mq.push_back(d);
        end
      end
    end
    chk("count", Count, mq.size());
    chk("empty", Empty, mq.size() == 0);
    chk("full", Full, mq.size() == DEPTH);
    chk("overflow", Overflow, mOvf);
    chk("txdata", TxData, mData);
    chk("txirq", TxIrq, IRQ_ON ? mIrq : 1'b0);
    if (!r) begin
      if (startPrev) begin
        TxBusy = 1;
        busyLeft = frameLen;
      end else if (busyLeft > 0 && !stuck) begin
        busyLeft--;
        if (busyLeft == 0) TxBusy = 0;
      end
    end
    if (TxBusy) lastBusy = cyc;
    startPrev = TxStart;
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic wr(input logic [7:0] d);
    WrEn = 1;
    WrData = d;
    step();
    WrEn = 0;
  endtask
  initial begin
    int n;
    bit popped;
    Reset = 0;
    run(2);
    chk("rst_state", 32'(dut.state), 32'(P_IDLE));
    chk("rst_data", TxData, 8'h00);
    Reset = 1;
    WrEn = 1;
    WrData = 8'hA5;
    step();
    WrEn = 0;
    chk("lat_empty", Empty, 0);
    chk("lat_start_early", TxStart, 0);
    step();
    chk("lat_start", TxStart, 1);
    chk("lat_data", TxData, 8'hA5);
    chk("lat_count", Count, 0);
    step();
    chk("lat_start_once", TxStart, 0);
    run(20);
    frameLen = 10;
    n = sent.size();
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    run(70);
    chk("b2b_pulses", sent.size() - n, 3);
    for (int i = 0; i < 3; i++) chk("b2b_data", sent[n+i], i + 1);
    frameLen = 3;
    stuck = 1;
    wr(8'hEE);
    run(6);
    for (int i = 0; i < 17; i++) wr(8'($urandom));
    chk("fill_count", Count, 16);
    chk("fill_full", Full, 1);
    chk("fill_ovf", Overflow, 1);
    chk("fill_state", 32'(dut.state), 32'(P_WAIT_DONE));
    Flush = 1;
    step();
    Flush = 0;
    chk("flush_count", Count, 0);
    chk("flush_empty", Empty, 1);
    chk("flush_ovf", Overflow, 0);
    chk("flush_state", 32'(dut.state), 32'(P_WAIT_DONE));
    for (int i = 0; i < 16; i++) wr(8'($urandom));
    chk("full16_count", Count, 16);
    stuck = 0;
    WrEn = 1;
    popped = 0;
    for (int i = 0; i < 30 && !popped; i++) begin
      WrData = 8'($urandom);
      step();
      if (TxStart) begin
        popped = 1;
        chk("fullpop_count", Count, 15);
        chk("fullpop_ovf", Overflow, 1);
      end
    end
    WrEn = 0;
    chk("fullpop_seen", popped, 1);
    run(16 * 12 + 20);
    chk("drain1_count", Count, 0);
    chk("drain1_model", mq.size(), 0);
    stuck = 1;
    wr(8'h5A);
    run(6);
    for (int i = 0; i < 5; i++) wr(8'($urandom));
    chk("midrst_count", Count, 5);
    chk("midrst_state", 32'(dut.state), 32'(P_WAIT_DONE));
    Reset = 0;
    stuck = 0;
    step();
    Reset = 1;
    chk("midrst_count0", Count, 0);
    chk("midrst_txstart", TxStart, 0);
    chk("midrst_txdata", TxData, 8'h00);
    chk("midrst_idle", 32'(dut.state), 32'(P_IDLE));
    TxIrqLevel = 2;
    stuck = 1;
    wr(8'h77);
    run(6);
    chk("irq_lvl0", TxIrq, IRQ_ON);
    for (int k = 1; k <= 3; k++) begin
      wr(8'(k));
      step();
      chk("irq_lvl", TxIrq, IRQ_ON ? k <= 2 : 0);
    end
    Flush = 1;
    step();
    Flush = 0;
    stuck = 0;
    run(30);
    for (int i = 0; i < 400; i++) begin
      WrEn = 1'($urandom_range(0, 1));
      WrData = 8'($urandom);
      Flush = $urandom_range(0, 39) == 0;
      TxIrqLevel = (AW+1)'($urandom_range(0, DEPTH));
      frameLen = $urandom_range(1, 6);
      step();
    end
    WrEn = 0;
    Flush = 0;
    run(16 * 14 + 20);
    chk("drain2_count", Count, 0);
    chk("drain2_model", mq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo_ctrl.md
Name: uart_tx_fifo_ctrl

Overview:
Transmit buffer and pump placed directly upstream of the UART transmitter. Bus-side writes go into a synchronous FIFO. A pump FSM pops one byte at a time, presents it on TxData, and issues a one-cycle TxStart pulse. It then tracks the transmitter's TxBusy until that frame completes and only then launches the next byte.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
ADDR_W, 4, log2(DEPTH); pointer width

Ports:
Clock  in  1  single system clock, all logic on rising edge
Reset  in  1  synchronous, active-low reset
WrEn  in  1  write strobe; pushes WrData when not Full
WrData  in  8  byte to enqueue
Flush  in  1  synchronous FIFO clear; does not abort the frame in flight
Full  out  1  FIFO holds DEPTH entries
Empty  out  1  FIFO holds 0 entries
Count  out  ADDR_W+1  current occupancy, 0..DEPTH
Overflow  out  1  sticky: a write was attempted while Full
TxStart  out  1  one-cycle start pulse to transmitter
TxData  out  8  byte for transmitter; stable from TxStart until next pop
TxBusy  in  1  transmitter busy; rises the cycle after TxStart, falls after last stop bit
TxIrqLevel  in  ADDR_W+1  low-water threshold (used only with optional feature)
TxIrq  out  1  low-water interrupt (see Optional Feature)

Behaviour:
- Reset (Reset=0 at an edge): pointers=0, Count=0, Empty=1, Full=0, Overflow=0, TxStart=0, TxData=8'h00, TxIrq=0, FSM=P_IDLE. All outputs are registered.
- Reset mid-frame: returns to P_IDLE. Reset of the transmitter is the system's responsibility.
- Write: WrEn && !Full stores WrData at wr_ptr. Count and Empty update at the same edge.
- WrEn && Full: data is dropped, Overflow is set to 1, and FIFO state is unchanged.
- Pointers wrap modulo DEPTH. Count is ADDR_W+1 bits wide, so DEPTH is representable.
- Flush: on the next edge, pointers and Count go to 0 and Overflow is cleared. Flush has priority over a same-cycle write and pop, and both are ignored. FSM state and TxData are untouched.
- Simultaneous write and pop: both occur and Count is unchanged. A write while Full combined with a same-cycle pop is still rejected; Full is evaluated before the edge.
- FSM states:
  - P_IDLE: if !Empty && !Flush, pop mem[rd_ptr] into TxData, advance rd_ptr, and go to P_START.
  - P_START: TxStart=1 for exactly this cycle; go to P_WAIT_BUSY.
  - P_WAIT_BUSY: when TxBusy=1, go to P_WAIT_DONE.
  - P_WAIT_DONE: when TxBusy=0, go to P_GAP.
  - P_GAP: one guard cycle; go to P_IDLE.
- Latency: a write at edge N into an empty FIFO gives Empty=0 after N, the pop at N+1, and TxStart=1 during the cycle after N+1.
- Back-to-back frames: TxBusy falls at edge M, TxStart for the next byte is high in the cycle after M+2. The next TxStart never overlaps TxBusy=1.
- TxStart is never asserted outside P_START.
- TxData changes only on a pop.

Optional Feature:
Macro UART_TX_FIFO_IRQ_EN.
- Defined: TxIrq is a registered output, TxIrq = (Count <= TxIrqLevel). It updates one edge after Count changes and is 0 in reset.
- Undefined: TxIrq is tied 0, TxIrqLevel is ignored, and no comparator is synthesised.

Decomposition:
- Package uart_pkg holds:
  - typedef enum uart_pump_state_t {P_IDLE, P_START, P_WAIT_BUSY, P_WAIT_DONE, P_GAP}
  - localparam UART_TX_FIFO_DEPTH_DEFAULT = 16
  - localparam UART_DATA_W = 8
- Sub-module sync_fifo holds the parameterised storage, pointers, Count, Full, Empty and Overflow, with push, pop and flush inputs.
- The top level holds the pump FSM, the TxData register and the IRQ logic.

Test Plan:
- Reset, then write 8'hA5 at edge 1 with TxBusy model idle -> Empty=0 after edge 1; TxData=8'hA5 and TxStart=1 in cycle 3 only; Count back to 0.
- Write 3 bytes 8'h01, 8'h02, 8'h03; transmitter model holds TxBusy 10 cycles per frame -> exactly 3 TxStart pulses, each at least 2 cycles after TxBusy falls, data in order.
- Write 17 bytes with TxBusy stuck 1 -> Count=16, Full=1, Overflow=1, 17th byte lost; then Flush -> Count=0, Empty=1, Overflow=0, FSM still in P_WAIT_DONE.
- Count=16 with WrEn and pop in the same cycle -> write rejected, Count=15, Overflow=1.
- Assert Reset during P_WAIT_DONE with Count=5 -> after the edge, Count=0, TxStart=0, TxData=8'h00, FSM=P_IDLE.
- With UART_TX_FIFO_IRQ_EN, TxIrqLevel=2 -> TxIrq=1 at Count<=2 and 0 at Count=3; without the macro, TxIrq stays 0 throughout.
